// File: rtl/fetch_pc_unit_pkg.sv
// ============================================================================
// fetch_pc_unit_pkg : shared constants, fetch-queue entry type, PC helper
// Revision 1.0
// ============================================================================
`default_nettype none

package fetch_pc_unit_pkg;

  localparam int          ILEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
    return {addr[ILEN-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : in-order {pc,instr} FIFO; flush beats push, head holds when empty
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pc_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       hold_q;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               w_do_pop, w_do_push;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & ~flush_i & (~full_o | w_do_pop);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Remembers the last presented head so the outputs stay stable once drained.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hold_q <= '0;
    end else if (!empty_o) begin
      hold_q <= mem_q[rd_ptr_q];
    end
  end

  assign head_o = empty_o ? hold_q : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : PC register, fetch/redirect control and decode-side fetch queue
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0]  pc_q, pc_d;
  logic         w_full, w_empty, w_deq, w_fetch;
  fetch_entry_t w_push_entry, w_head;

  assign out_valid = ~w_empty;
  assign w_deq     = out_valid & out_ready;
  assign w_fetch   = ~stall & ~redirect_vld & (~w_full | w_deq);

  always_comb begin
    pc_d = pc_q;
    if (redirect_vld) begin
      pc_d = word_align(redirect_pc);
    end else if (w_fetch) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr          = pc_q;
  assign w_push_entry.pc    = pc_q;
  assign w_push_entry.instr = imem_rdata;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_l   (rst_l),
    .push_i  (w_fetch),
    .pop_i   (w_deq),
    .flush_i (redirect_vld),
    .wdata_i (w_push_entry),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// tb_fetch_pc_unit : directed scenarios plus randomized run against a queue model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC, queue of {pc,instr}, last presented head.
  logic [31:0] mpc;
  logic [63:0] mq[$];
  logic [63:0] mlast;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] addr);
    logic [31:0] w;
    w = {2'b00, addr[31:2]};
    return (w * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  assign imem_rdata = memf(imem_addr);

  fetch_pc_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (QD)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc)
  );

  task automatic model_reset();
    mq.delete();
    mpc   = 32'h0;
    mlast = 64'h0;
  endtask

  // Advance one clock edge and apply the same rules to the model.
  task automatic tick();
    int   sz;
    logic dq, fe;
    @(posedge clk);
    sz = mq.size();
    dq = (sz > 0) && out_ready;
    fe = !stall && !redirect_vld && ((sz < QD) || dq);
    if (dq) void'(mq.pop_front());
    if (redirect_vld) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else if (fe) begin
      mq.push_back({mpc, memf(mpc)});
      mpc = mpc + 32'd4;
    end
    if (mq.size() > 0) mlast = mq[0];
    #1;
  endtask

  task automatic do_reset();
    rst_l        = 1'b0;
    stall        = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    out_ready    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; stall = 1'b0; redirect_vld = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
    n_tests++;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %08h exp 00000000", imem_addr); end
    n_tests++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_out: got pc %08h instr %08h exp 0/0", out_pc, out_instr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== memf(32'h0)) begin
      n_fail++;
      $display("FAIL first_fetch: got v%0b pc %08h instr %08h exp v1 pc 00000000 instr %08h",
               out_valid, out_pc, out_instr, memf(32'h0));
    end
    n_tests++;
    if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL first_fetch_addr: got %08h exp 00000004", imem_addr); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== memf(32'(4*i))) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v%0b pc %08h instr %08h exp v1 pc %08h instr %08h",
                 i, out_valid, out_pc, out_instr, 32'(4*i), memf(32'(4*i)));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (imem_addr !== 32'h8 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got addr %08h pc %08h v%0b exp addr 00000008 pc 00000000 v1",
               imem_addr, out_pc, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== memf(32'(4*i))) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got v%0b pc %08h instr %08h exp v1 pc %08h",
                 i, out_valid, out_pc, out_instr, 32'(4*i));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    tick(); tick();
    redirect_vld = 1'b1;
    redirect_pc  = 32'h43;
    tick();
    redirect_vld = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL redirect_flush: got v%0b addr %08h exp v0 addr 00000040", out_valid, imem_addr);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== memf(32'h40)) begin
      n_fail++;
      $display("FAIL redirect_target: got v%0b pc %08h instr %08h exp v1 pc 00000040 instr %08h",
               out_valid, out_pc, out_instr, memf(32'h40));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready    = 1'b1;
    redirect_vld = 1'b1;
    redirect_pc  = 32'hFFFF_FFFC;
    tick();
    redirect_vld = 1'b0;
    n_tests++;
    if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %08h exp fffffffc", imem_addr); end
    tick();
    n_tests++;
    if (out_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_top: got pc %08h addr %08h exp fffffffc/00000000", out_pc, imem_addr);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== memf(32'h0)) begin
      n_fail++; $display("FAIL wrap_zero: got v%0b pc %08h exp v1 pc 00000000", out_valid, out_pc);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    out_ready = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (imem_addr !== 32'h4 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: got addr %08h pc %08h v%0b exp 00000004/00000000/1",
                 i, imem_addr, out_pc, out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL stall_drain: got v%0b pc %08h addr %08h exp v0 pc 00000000 addr 00000004",
               out_valid, out_pc, imem_addr);
    end
    stall = 1'b0;
    tick(); tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8) begin
      n_fail++; $display("FAIL stall_resume: got v%0b pc %08h exp v1 pc 00000008", out_valid, out_pc);
    end
    #2;
    rst_l = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v%0b addr %08h pc %08h exp 0/00000000/00000000",
               out_valid, imem_addr, out_pc);
    end
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== memf(32'h0)) begin
      n_fail++; $display("FAIL reset_restart: got v%0b pc %08h exp v1 pc 00000000", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      stall        = ($urandom_range(0, 3) == 0);
      redirect_vld = ($urandom_range(0, 9) == 0);
      out_ready    = ($urandom_range(0, 4) < 3);
      redirect_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
      tick();
      exp_v = (mq.size() > 0);
      n_tests++;
      if (out_valid !== exp_v) begin
        n_fail++; $display("FAIL rand_valid c%0d: got %0b exp %0b", c, out_valid, exp_v);
      end
      n_tests++;
      if (out_pc !== mlast[63:32] || out_instr !== mlast[31:0]) begin
        n_fail++;
        $display("FAIL rand_head c%0d: got pc %08h instr %08h exp pc %08h instr %08h",
                 c, out_pc, out_instr, mlast[63:32], mlast[31:0]);
      end
      n_tests++;
      if (imem_addr !== mpc) begin
        n_fail++; $display("FAIL rand_addr c%0d: got %08h exp %08h", c, imem_addr, mpc);
      end
    end
    stall = 1'b0; redirect_vld = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_stall_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
